// File: rtl/nib_pkg.sv
// Shared constants and state encoding for the NIB track cache.
// One NIB track is 13 SD sectors of 512 bytes.
package nib_pkg;

  localparam int SECT_BYTES  = 512;
  localparam int TRACK_BYTES = 6656;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_CHK,
    WB_REQ,
    WB_XFER,
    RD_REQ,
    RD_XFER
  } state_t;

endpackage

// File: rtl/nib_track_ram.sv
// 8192x8 true dual-port track buffer, registered reads on both ports.
// Port B returns its own write data on a write cycle.
module nib_track_ram
  import nib_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [12:0] addr_a,
  input  logic        we_a,
  input  logic [7:0]  di_a,
  output logic [7:0]  do_a,
  input  logic [12:0] addr_b,
  input  logic        we_b,
  input  logic [7:0]  di_b,
  output logic [7:0]  do_b
);

  localparam int DEPTH = 16 * SECT_BYTES;

  logic [7:0] mem [DEPTH];

  // Port A is written last so an SD write beats a drive write
  always_ff @(posedge clk) begin
    if (we_b) mem[addr_b] <= di_b;
    if (we_a) mem[addr_a] <= di_a;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      do_a <= 8'h00;
      do_b <= 8'h00;
    end else begin
      do_a <= mem[addr_a];
      do_b <= we_b ? di_b : mem[addr_b];
    end
  end

endmodule

// File: rtl/nib_track_cache.sv
// Single-track NIB cache between hps_io SD blocks and the Disk II drive.
// Loads on head movement, writes back modified tracks, stalls the CPU.
module nib_track_cache
  import nib_pkg::*;
#(
  parameter int SECT_PER_TRACK = 13,
  parameter int MAX_TRACK      = 34
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        img_mounted,
  input  logic        img_readonly,
  input  logic [63:0] img_size,
  input  logic [5:0]  track,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [8:0]  sd_buff_addr,
  input  logic [7:0]  sd_buff_dout,
  input  logic        sd_buff_wr,
  output logic [7:0]  sd_buff_din,
  input  logic [12:0] ram_addr,
  input  logic [7:0]  ram_di,
  input  logic        ram_we,
  output logic [7:0]  ram_do,
  output logic        cpu_wait,
  output logic        dirty,
  output logic        valid,
  output logic        disk_act
);

  state_t      state, state_n;
  logic [5:0]  cur_track, cur_track_n;
  logic [3:0]  sec, sec_n;
  logic [31:0] lba, lba_n;
  logic        dirty_n, valid_n;
  logic        pend_mount, pend_n;
  logic        ack_q;

  logic        mount_req;
  logic        ack_rise, ack_fall;
  logic        last_sec;
  logic        fits;
  logic [63:0] need;
  logic        sd_we;

  function automatic logic [31:0] lba_of(input logic [5:0] t);
    return {26'd0, t} * 32'(SECT_PER_TRACK);
  endfunction

  always_comb begin
    mount_req = pend_mount | img_mounted;
    ack_rise  = sd_ack & ~ack_q;
    ack_fall  = ~sd_ack & ack_q;
    last_sec  = sec == 4'(SECT_PER_TRACK - 1);
    need      = ({58'd0, track} + 64'd1) * 64'(TRACK_BYTES);
    fits      = (img_size != 64'd0)
              && (track <= 6'(MAX_TRACK))
              && (need <= img_size);
  end

  always_comb begin
    state_n     = state;
    cur_track_n = cur_track;
    sec_n       = sec;
    lba_n       = lba;
    dirty_n     = dirty | (ram_we & valid);
    valid_n     = valid;
    pend_n      = mount_req;
    unique case (state)
      IDLE: begin
        if (mount_req) begin
          pend_n  = 1'b0;
          dirty_n = 1'b0;
          valid_n = 1'b0;
          state_n = LOAD_CHK;
        end else if (track != cur_track) begin
          if (dirty & ~img_readonly & valid) begin
            sec_n   = 4'd0;
            lba_n   = lba_of(cur_track);
            state_n = WB_REQ;
          end else begin
            state_n = LOAD_CHK;
          end
        end
      end
      LOAD_CHK: begin
        // buffer is about to be overwritten or is unusable
        cur_track_n = track;
        dirty_n     = 1'b0;
        valid_n     = 1'b0;
        if (fits) begin
          sec_n   = 4'd0;
          lba_n   = lba_of(track);
          state_n = RD_REQ;
        end else begin
          state_n = IDLE;
        end
      end
      WB_REQ: begin
        if (ack_rise) state_n = WB_XFER;
      end
      WB_XFER: begin
        if (ack_fall) begin
          if (mount_req) begin
            state_n = IDLE;
          end else if (last_sec) begin
            dirty_n = 1'b0;
            state_n = LOAD_CHK;
          end else begin
            sec_n   = sec + 4'd1;
            lba_n   = lba + 32'd1;
            state_n = WB_REQ;
          end
        end
      end
      RD_REQ: begin
        if (ack_rise) state_n = RD_XFER;
      end
      RD_XFER: begin
        if (ack_fall) begin
          if (mount_req) begin
            state_n = IDLE;
          end else if (last_sec) begin
            valid_n = 1'b1;
            state_n = IDLE;
          end else begin
            sec_n   = sec + 4'd1;
            lba_n   = lba + 32'd1;
            state_n = RD_REQ;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cur_track  <= 6'h3F;
      sec        <= 4'd0;
      lba        <= 32'd0;
      dirty      <= 1'b0;
      valid      <= 1'b0;
      pend_mount <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state      <= state_n;
      cur_track  <= cur_track_n;
      sec        <= sec_n;
      lba        <= lba_n;
      dirty      <= dirty_n;
      valid      <= valid_n;
      pend_mount <= pend_n;
      ack_q      <= sd_ack;
    end
  end

  assign sd_rd    = state == RD_REQ;
  assign sd_wr    = state == WB_REQ;
  assign sd_lba   = lba;
  assign cpu_wait = (state != IDLE) && (state != LOAD_CHK);
  assign disk_act = cpu_wait;
  assign sd_we    = sd_buff_wr
                  & ((state == RD_REQ) | (state == RD_XFER));

  nib_track_ram u_ram (
    .clk    (clk_sys),
    .rst_n  (reset_n),
    .addr_a ({sec, sd_buff_addr}),
    .we_a   (sd_we),
    .di_a   (sd_buff_dout),
    .do_a   (sd_buff_din),
    .addr_b (ram_addr),
    .we_b   (ram_we & valid),
    .di_b   (ram_di),
    .do_b   (ram_do)
  );

endmodule

// File: tb/tb_nib_track_cache.sv
// Directed bench for nib_track_cache with a small hps_io sector model.
// Image contents come from img_byte(lba, offset).
module tb_nib_track_cache;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        img_mounted = 1'b0;
  logic        img_readonly = 1'b0;
  logic [63:0] img_size = 64'd0;
  logic [5:0]  track = 6'd0;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr;
  logic        sd_ack = 1'b0;
  logic [8:0]  sd_buff_addr = 9'd0;
  logic [7:0]  sd_buff_dout = 8'd0;
  logic        sd_buff_wr = 1'b0;
  logic [7:0]  sd_buff_din;
  logic [12:0] ram_addr = 13'd0;
  logic [7:0]  ram_di = 8'd0;
  logic        ram_we = 1'b0;
  logic [7:0]  ram_do;
  logic        cpu_wait, dirty, valid, disk_act;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] wb_buf [512];

  typedef struct {
    logic [12:0] addr;
    logic        we;
    logic [7:0]  di;
    logic [7:0]  exp_do;
    logic        exp_dirty;
  } vec_t;
  vec_t vecs [7];

  nib_track_cache dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .img_mounted  (img_mounted),
    .img_readonly (img_readonly),
    .img_size     (img_size),
    .track        (track),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_addr (sd_buff_addr),
    .sd_buff_dout (sd_buff_dout),
    .sd_buff_wr   (sd_buff_wr),
    .sd_buff_din  (sd_buff_din),
    .ram_addr     (ram_addr),
    .ram_di       (ram_di),
    .ram_we       (ram_we),
    .ram_do       (ram_do),
    .cpu_wait     (cpu_wait),
    .dirty        (dirty),
    .valid        (valid),
    .disk_act     (disk_act)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [7:0] img_byte(input logic [31:0] l, input int off);
    logic [31:0] v;
    v = l * 32'd31 + 32'(off) * 32'd7 + 32'(off >> 5);
    return v[7:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One sector as hps_io would run it; mount_at pulses img_mounted mid-sector
  task automatic serve(input logic wr, input logic [31:0] l, input int mount_at);
    int n;
    n = 0;
    while (!(sd_rd || sd_wr) && n < 300) begin
      @(negedge clk_sys);
      n++;
    end
    if (!(sd_rd || sd_wr)) begin
      chk($sformatf("req_timeout_lba%0d", l), 64'd0, 64'd1);
      return;
    end
    chk($sformatf("req_kind_lba%0d", l), 64'({sd_wr, sd_rd}),
        wr ? 64'd2 : 64'd1);
    chk("req_lba", 64'(sd_lba), 64'(l));
    sd_ack = 1'b1;
    if (!wr) begin
      for (int i = 0; i < 512; i++) begin
        @(negedge clk_sys);
        sd_buff_addr = 9'(i);
        sd_buff_dout = img_byte(l, i);
        sd_buff_wr   = 1'b1;
        img_mounted  = (i == mount_at);
      end
      @(negedge clk_sys);
      sd_buff_wr  = 1'b0;
      img_mounted = 1'b0;
    end else begin
      for (int i = 0; i <= 512; i++) begin
        @(negedge clk_sys);
        if (i > 0) wb_buf[i-1] = sd_buff_din;
        sd_buff_addr = 9'(i);
      end
    end
    chk("req_dropped", 64'({sd_wr, sd_rd}), 64'd0);
    chk("stall_in_xfer", 64'(cpu_wait), 64'd1);
    sd_ack = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic idle_watch(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    repeat (cycles) begin
      @(negedge clk_sys);
      if (sd_rd || sd_wr) seen = 1'b1;
    end
    chk(name, 64'(seen), 64'd0);
  endtask

  task automatic drive_write(input logic [12:0] a, input logic [7:0] d);
    ram_addr = a;
    ram_di   = d;
    ram_we   = 1'b1;
    @(negedge clk_sys);
    ram_we   = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{13'd0,    1'b0, 8'h00, img_byte(39, 0),   1'b0};
    vecs[1] = '{13'd511,  1'b0, 8'h00, img_byte(39, 511), 1'b0};
    vecs[2] = '{13'd512,  1'b0, 8'h00, img_byte(40, 0),   1'b0};
    vecs[3] = '{13'd6655, 1'b0, 8'h00, img_byte(51, 511), 1'b0};
    vecs[4] = '{13'd100,  1'b1, 8'hA5, 8'hA5,             1'b1};
    vecs[5] = '{13'd100,  1'b0, 8'h00, 8'hA5,             1'b1};
    vecs[6] = '{13'd101,  1'b0, 8'h00, img_byte(39, 101), 1'b1};

    repeat (3) @(negedge clk_sys);
    chk("rst_sd_lba", 64'(sd_lba), 64'd0);
    chk("rst_sd_rd", 64'(sd_rd), 64'd0);
    chk("rst_sd_wr", 64'(sd_wr), 64'd0);
    chk("rst_cpu_wait", 64'(cpu_wait), 64'd0);
    chk("rst_dirty", 64'(dirty), 64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_disk_act", 64'(disk_act), 64'd0);
    chk("rst_ram_do", 64'(ram_do), 64'd0);
    chk("rst_buff_din", 64'(sd_buff_din), 64'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_sys);

    // clean load of track 3
    img_size    = 64'd232960;
    track       = 6'd3;
    img_mounted = 1'b1;
    @(negedge clk_sys);
    img_mounted = 1'b0;
    for (int s = 0; s < 13; s++) serve(1'b0, 32'(39 + s), -1);
    chk("load3_valid", 64'(valid), 64'd1);
    chk("load3_cpu_wait", 64'(cpu_wait), 64'd0);
    chk("load3_disk_act", 64'(disk_act), 64'd0);

    for (int k = 0; k < 7; k++) begin
      ram_addr = vecs[k].addr;
      ram_we   = vecs[k].we;
      ram_di   = vecs[k].di;
      @(negedge clk_sys);
      chk($sformatf("vec%0d_ram_do", k), 64'(ram_do), 64'(vecs[k].exp_do));
      chk($sformatf("vec%0d_dirty", k), 64'(dirty), 64'(vecs[k].exp_dirty));
    end
    ram_we = 1'b0;

    // write-back of track 3 then load of track 4
    track = 6'd4;
    serve(1'b1, 32'd39, -1);
    chk("wb_byte100", 64'(wb_buf[100]), 64'hA5);
    chk("wb_byte0", 64'(wb_buf[0]), 64'(img_byte(39, 0)));
    chk("wb_byte511", 64'(wb_buf[511]), 64'(img_byte(39, 511)));
    for (int s = 1; s < 13; s++) serve(1'b1, 32'(39 + s), -1);
    chk("wb_dirty_clear", 64'(dirty), 64'd0);
    for (int s = 0; s < 13; s++) serve(1'b0, 32'(52 + s), -1);
    chk("load4_valid", 64'(valid), 64'd1);

    // read-only image: modified track is dropped
    drive_write(13'd7, 8'h3C);
    chk("ro_dirty_set", 64'(dirty), 64'd1);
    img_readonly = 1'b1;
    track        = 6'd5;
    serve(1'b0, 32'd65, -1);
    chk("ro_dirty_clear", 64'(dirty), 64'd0);
    for (int s = 1; s < 13; s++) serve(1'b0, 32'(65 + s), -1);
    img_readonly = 1'b0;
    chk("load5_valid", 64'(valid), 64'd1);

    // remount during sector 5 of a load
    track = 6'd3;
    for (int s = 0; s < 5; s++) serve(1'b0, 32'(39 + s), -1);
    serve(1'b0, 32'd44, 100);
    for (int s = 0; s < 13; s++) serve(1'b0, 32'(39 + s), -1);
    chk("remount_dirty", 64'(dirty), 64'd0);
    chk("remount_valid", 64'(valid), 64'd1);

    // reset in the middle of a write-back
    drive_write(13'd10, 8'h5A);
    chk("rstwb_dirty_set", 64'(dirty), 64'd1);
    track = 6'd6;
    n = 0;
    while (!sd_wr && n < 300) begin
      @(negedge clk_sys);
      n++;
    end
    chk("rstwb_req", 64'(sd_wr), 64'd1);
    chk("rstwb_lba", 64'(sd_lba), 64'd39);
    sd_ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_sys);
      sd_buff_addr = 9'(i);
    end
    chk("rstwb_stall", 64'(cpu_wait), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("rstwb_sd_wr", 64'(sd_wr), 64'd0);
    chk("rstwb_cpu_wait", 64'(cpu_wait), 64'd0);
    chk("rstwb_disk_act", 64'(disk_act), 64'd0);
    chk("rstwb_cur_track", 64'(dut.cur_track), 64'h3F);
    chk("rstwb_dirty", 64'(dirty), 64'd0);
    chk("rstwb_valid", 64'(valid), 64'd0);
    @(negedge clk_sys);
    sd_ack = 1'b0;
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    for (int s = 0; s < 13; s++) serve(1'b0, 32'(78 + s), -1);
    ram_addr = 13'd0;
    @(negedge clk_sys);
    chk("load6_ram_do0", 64'(ram_do), 64'(img_byte(78, 0)));
    chk("load6_valid", 64'(valid), 64'd1);

    // out-of-range tracks on a 20-track image
    img_size    = 64'd133120;
    track       = 6'd25;
    img_mounted = 1'b1;
    @(negedge clk_sys);
    img_mounted = 1'b0;
    idle_watch("oor25_no_access", 40);
    chk("oor25_valid", 64'(valid), 64'd0);
    chk("oor25_cpu_wait", 64'(cpu_wait), 64'd0);
    drive_write(13'd5, 8'hFF);
    chk("oor25_dirty", 64'(dirty), 64'd0);
    track = 6'd20;
    idle_watch("oor20_no_access", 40);
    chk("oor20_valid", 64'(valid), 64'd0);
    track = 6'd19;
    for (int s = 0; s < 13; s++) serve(1'b0, 32'(247 + s), -1);
    chk("load19_valid", 64'(valid), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nib_track_cache.md
Name: nib_track_cache

Overview:
- Disk-track cache between the hps_io SD-block interface and the Disk II controller inside apple2_top.
- Holds one 6656-byte NIB track (13 × 512-byte sectors) in on-chip RAM, loads it from the mounted image when the head moves, and writes it back when the drive has modified it.
- Stalls the CPU while a transfer runs.
- Replaces the inline read-only track loader in emu and adds write-back.

Parameters:
- SECT_PER_TRACK, 13, 512-byte SD sectors per NIB track.
- MAX_TRACK, 34, highest loadable track number.

Ports:
- clk_sys  in  1  system clock, 14 MHz domain.
- reset_n  in  1  async active-low reset.
- img_mounted  in  1  one-cycle pulse: new image mounted.
- img_readonly  in  1  image is write-protected.
- img_size  in  64  image size in bytes; 0 means no disk.
- track  in  6  current head track from the drive.
- sd_lba  out  32  SD sector address.
- sd_rd  out  1  read request.
- sd_wr  out  1  write request.
- sd_ack  in  1  hps_io acknowledge; high for the whole sector.
- sd_buff_addr  in  9  byte index within the sector.
- sd_buff_dout  in  8  read data from hps_io.
- sd_buff_wr  in  1  read-data strobe.
- sd_buff_din  out  8  write data to hps_io.
- ram_addr  in  13  drive-side byte address (0..6655).
- ram_di  in  8  drive write data.
- ram_we  in  1  drive write strobe.
- ram_do  out  8  drive read data.
- cpu_wait  out  1  stall request to apple2_top.
- dirty  out  1  buffer differs from the image.
- valid  out  1  buffer holds the track in cur_track.
- disk_act  out  1  SD transfer in progress.

Behaviour:
- Reset values: sd_lba 0, sd_rd 0, sd_wr 0, cpu_wait 0, dirty 0, valid 0, disk_act 0, ram_do 0, sd_buff_din 0. Internal: cur_track 6'h3F, sec 0, state IDLE.
- Buffer: true dual-port 8192×8.
  - Port A (SD side) address is {sec[3:0], sd_buff_addr}.
    - Written on sd_buff_wr during a read sequence.
    - Read every cycle into sd_buff_din with 1-cycle latency.
  - Port B (drive side) address is ram_addr.
    - ram_do is registered, 1-cycle latency.
    - On write, ram_do returns ram_di (write-through).
  - ram_we with valid sets dirty the same cycle. Writes with valid=0 are ignored.
- States:
  - IDLE → if pend_mount: clear dirty and valid, clear pend_mount, go to LOAD_CHK.
  - IDLE → elif track≠cur_track: if dirty & ~img_readonly & valid go to WB_REQ (sec 0, lba = cur_track×13); else go to LOAD_CHK.
  - LOAD_CHK:
    - Latch cur_track←track.
    - If img_size==0, track>MAX_TRACK, or (track+1)×6656>img_size: valid←0 and return to IDLE with no SD access.
    - Otherwise sec←0, lba = track×13, go to RD_REQ.
  - WB_REQ / RD_REQ: assert sd_wr / sd_rd with sd_lba; wait for sd_ack rise, then drop the request and go to XFER.
  - WB_XFER / RD_XFER: on sd_ack fall, sec+1 and lba+1.
    - If sec was SECT_PER_TRACK−1, the sequence is done: WB clears dirty and goes to LOAD_CHK; RD sets valid and goes to IDLE.
    - Otherwise return to the matching REQ state.
- cpu_wait and disk_act are high in every state except IDLE and LOAD_CHK.
- Simultaneous events:
  - A track change during a sequence is not acted on until the next IDLE, which re-compares against cur_track.
  - img_mounted at any time sets pend_mount. A sequence in progress still completes its current sector (the handshake is never broken mid-ack); the sequence is then abandoned and the block returns to IDLE, where pend_mount is serviced.
  - A drive write in the same cycle as sd_buff_wr to the same address: the SD write wins.
- Arithmetic: lba is computed in 32 bits (track×13 zero-extended). sec is 4 bits and never exceeds 12.
- Async reset mid-transfer: requests drop immediately. hps_io completes its sector harmlessly.

Decomposition:
- Package nib_pkg holds:
  - SECT_BYTES=512.
  - TRACK_BYTES=6656.
  - state enum {IDLE, LOAD_CHK, WB_REQ, WB_XFER, RD_REQ, RD_XFER}.
- Sub-module nib_track_ram: a true-dual-port 8192×8 RAM with registered outputs and port-B write-through.

Test Plan:
- Clean load: mount a 232960-byte image, set track=3 → sd_rd with lba 39..51, 13 acks of 512 bytes each. Then valid=1, cpu_wait drops after the 13th ack fall, and ram_do at addr 0 equals image byte 19968.
- Write-back: with track 3 loaded, write 0xA5 to ram_addr 100 (dirty=1), then set track=4. Expect sd_wr lba 39..51 with sd_buff_din byte 100 of sector 0 equal to 0xA5, then dirty=0, then sd_rd lba 52..64.
- Read-only: same as write-back with img_readonly=1 → no sd_wr, read of lba 52 starts directly, dirty cleared.
- Out of range: img_size=6656×20, set track=25 → no SD access, valid=0, ram_we ignored, dirty stays 0.
- Remount mid-read: pulse img_mounted during sector 5 of a load → sector 5 completes, no sector-6 request, then a fresh load of the current track, dirty=0.
- Reset mid-write-back: assert reset_n=0 during WB_XFER → sd_wr=0 and cpu_wait=0 at once, cur_track=6'h3F, and a reload follows after reset is released.
